// File: rtl/entry_shift_reg_param_if.sv
// Player-select / button / display bundle for the multi-player
// code-entry shift register.
interface entry_shift_reg_param_if #(
  parameter int DIGIT_W     = 4,
  parameter int DEPTH       = 4,
  parameter int NUM_PLAYERS = 2
);
  localparam int BW = DIGIT_W * DEPTH;
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_PLAYERS-1:0] enable;
  logic [DIGIT_W-1:0]     toggle_entry;
  logic                   auth_button;
  logic                   del_button;
  logic                   log_out;
  logic [BW-1:0]          entered;
  logic [CW-1:0]          count;
  logic                   valid_bit;
  logic [NUM_PLAYERS-1:0] valid_vec;
  logic                   err_pulse;

  modport master (
    output enable,
    output toggle_entry,
    output auth_button,
    output del_button,
    output log_out,
    input  entered,
    input  count,
    input  valid_bit,
    input  valid_vec,
    input  err_pulse
  );

  modport slave (
    input  enable,
    input  toggle_entry,
    input  auth_button,
    input  del_button,
    input  log_out,
    output entered,
    output count,
    output valid_bit,
    output valid_vec,
    output err_pulse
  );
endinterface

// File: rtl/entry_shift_reg_param.sv
// Per-player digit-entry buffers with edge-detected enter/backspace,
// full lockout, log-out clear and a registered error pulse.
module entry_shift_reg_param #(
  parameter int DIGIT_W     = 4,
  parameter int DEPTH       = 4,
  parameter int NUM_PLAYERS = 2
) (
  input logic clock,
  input logic rst,
  entry_shift_reg_param_if.slave bus
);
  localparam int BW = DIGIT_W * DEPTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (NUM_PLAYERS > 1) ?
                      $clog2(NUM_PLAYERS) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  logic [BW-1:0] buf_q [NUM_PLAYERS];
  logic [BW-1:0] buf_d [NUM_PLAYERS];
  logic [CW-1:0] cnt_q [NUM_PLAYERS];
  logic [CW-1:0] cnt_d [NUM_PLAYERS];
  state_t        st_q  [NUM_PLAYERS];
  state_t        st_d  [NUM_PLAYERS];

  logic err_q, err_d;
  logic auth_q, auth_d;
  logic del_q, del_d;
  logic auth_arm_q, auth_arm_d;
  logic del_arm_q, del_arm_d;

  logic          sel_ok;
  logic [SW-1:0] sel;
  logic          auth_edge;
  logic          del_edge;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cnt_dec;

  always_comb begin
    sel    = '0;
    sel_ok = (bus.enable != '0) &&
             ((bus.enable &
               (bus.enable - NUM_PLAYERS'(1))) == '0);
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.enable[i]) sel = SW'(i);
    end
  end

  // Arm flags stop a button held through reset from firing on release.
  always_comb begin
    auth_d     = bus.auth_button;
    del_d      = bus.del_button;
    auth_arm_d = auth_arm_q | ~bus.auth_button;
    del_arm_d  = del_arm_q | ~bus.del_button;
    auth_edge  = bus.auth_button & ~auth_q & auth_arm_q;
    del_edge   = bus.del_button & ~del_q & del_arm_q;
  end

  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    err_d   = 1'b0;
    cnt_inc = cnt_q[sel] + CW'(1);
    cnt_dec = cnt_q[sel] - CW'(1);
    if (!sel_ok) begin
      err_d = auth_edge | del_edge | bus.log_out;
    end else if (bus.log_out) begin
      buf_d[sel] = '0;
      cnt_d[sel] = '0;
      st_d[sel]  = EMPTY;
    end else if (auth_edge && del_edge) begin
      err_d = 1'b1;
    end else if (auth_edge) begin
      if (st_q[sel] == FULL) begin
        err_d = 1'b1;
      end else begin
        buf_d[sel] = (buf_q[sel] << DIGIT_W) |
                     BW'(bus.toggle_entry);
        cnt_d[sel] = cnt_inc;
        st_d[sel]  = (cnt_inc == CW'(DEPTH)) ?
                     FULL : PARTIAL;
      end
    end else if (del_edge) begin
      if (st_q[sel] == EMPTY) begin
        err_d = 1'b1;
      end else begin
        buf_d[sel] = buf_q[sel] >> DIGIT_W;
        cnt_d[sel] = cnt_dec;
        st_d[sel]  = (cnt_dec == '0) ? EMPTY : PARTIAL;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        buf_q[i] <= '0;
        cnt_q[i] <= '0;
        st_q[i]  <= EMPTY;
      end
      err_q      <= 1'b0;
      auth_q     <= 1'b0;
      del_q      <= 1'b0;
      auth_arm_q <= ~bus.auth_button;
      del_arm_q  <= ~bus.del_button;
    end else begin
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      st_q       <= st_d;
      err_q      <= err_d;
      auth_q     <= auth_d;
      del_q      <= del_d;
      auth_arm_q <= auth_arm_d;
      del_arm_q  <= del_arm_d;
    end
  end

  always_comb begin
    bus.entered   = '0;
    bus.count     = '0;
    bus.valid_bit = 1'b0;
    bus.err_pulse = err_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      bus.valid_vec[i] = (st_q[i] == FULL);
    end
    if (sel_ok) begin
      bus.entered   = buf_q[sel];
      bus.count     = cnt_q[sel];
      bus.valid_bit = (st_q[sel] == FULL);
    end
  end
endmodule

// File: tb/tb_entry_shift_reg_param.sv
// Bench for entry_shift_reg_param: vector table plus hand sequences,
// expected outputs queued at drive time and popped at sample time.
module tb_entry_shift_reg_param;
  typedef struct {
    logic        rst_n;
    logic [1:0]  en;
    logic [3:0]  tog;
    logic        a;
    logic        d;
    logic        lo;
    logic [15:0] ent;
    logic [2:0]  cnt;
    logic        vb;
    logic [1:0]  vv;
    logic        err;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t tbl [$];
  vec_t sb  [$];

  entry_shift_reg_param_if #(
    .DIGIT_W(4), .DEPTH(4), .NUM_PLAYERS(2)
  ) bus ();

  entry_shift_reg_param #(
    .DIGIT_W(4), .DEPTH(4), .NUM_PLAYERS(2)
  ) dut (
    .clock(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [1:0] en,
                     input logic [3:0] tog, input logic a,
                     input logic d, input logic lo,
                     input logic [15:0] ent, input logic [2:0] cnt,
                     input logic vb, input logic [1:0] vv,
                     input logic err);
    vec_t v;
    v.rst_n = r; v.en = en; v.tog = tog;
    v.a = a; v.d = d; v.lo = lo;
    v.ent = ent; v.cnt = cnt; v.vb = vb;
    v.vv = vv; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input string f,
                     input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s %s: got %h want %h", nm, f, got, want);
    end
  endtask

  // Drive at a negedge, push expectation, sample at the next negedge.
  task automatic step(input string nm, input vec_t v);
    vec_t e;
    rst              = v.rst_n;
    bus.enable       = v.en;
    bus.toggle_entry = v.tog;
    bus.auth_button  = v.a;
    bus.del_button   = v.d;
    bus.log_out      = v.lo;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk(nm, "entered", bus.entered, e.ent);
    chk(nm, "count", 16'(bus.count), 16'(e.cnt));
    chk(nm, "valid_bit", 16'(bus.valid_bit), 16'(e.vb));
    chk(nm, "valid_vec", 16'(bus.valid_vec), 16'(e.vv));
    chk(nm, "err_pulse", 16'(bus.err_pulse), 16'(e.err));
  endtask

  task automatic run_tbl(input string pfx);
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("%s%0d", pfx, i), tbl[i]);
    tbl.delete();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    bus.enable = 2'b01;
    bus.toggle_entry = 4'h0;
    bus.auth_button = 1'b0;
    bus.del_button = 1'b0;
    bus.log_out = 1'b0;
    @(negedge clk);

    // reset
    add(0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    // fill player 0 with 1,2,3,4
    add(1, 2'b01, 1, 1, 0, 0, 16'h0001, 1, 0, 2'b00, 0);
    add(1, 2'b01, 1, 0, 0, 0, 16'h0001, 1, 0, 2'b00, 0);
    add(1, 2'b01, 2, 1, 0, 0, 16'h0012, 2, 0, 2'b00, 0);
    add(1, 2'b01, 2, 0, 0, 0, 16'h0012, 2, 0, 2'b00, 0);
    add(1, 2'b01, 3, 1, 0, 0, 16'h0123, 3, 0, 2'b00, 0);
    add(1, 2'b01, 3, 0, 0, 0, 16'h0123, 3, 0, 2'b00, 0);
    add(1, 2'b01, 4, 1, 0, 0, 16'h1234, 4, 1, 2'b01, 0);
    add(1, 2'b01, 4, 0, 0, 0, 16'h1234, 4, 1, 2'b01, 0);
    // lockout, backspace, refill
    add(1, 2'b01, 5, 1, 0, 0, 16'h1234, 4, 1, 2'b01, 1);
    add(1, 2'b01, 5, 0, 0, 0, 16'h1234, 4, 1, 2'b01, 0);
    add(1, 2'b01, 0, 0, 1, 0, 16'h0123, 3, 0, 2'b00, 0);
    add(1, 2'b01, 0, 0, 0, 0, 16'h0123, 3, 0, 2'b00, 0);
    add(1, 2'b01, 9, 1, 0, 0, 16'h1239, 4, 1, 2'b01, 0);
    add(1, 2'b01, 9, 0, 0, 0, 16'h1239, 4, 1, 2'b01, 0);
    add(1, 2'b01, 0, 0, 1, 0, 16'h0123, 3, 0, 2'b00, 0);
    add(1, 2'b01, 0, 0, 0, 0, 16'h0123, 3, 0, 2'b00, 0);
    add(1, 2'b01, 0, 0, 1, 0, 16'h0012, 2, 0, 2'b00, 0);
    add(1, 2'b01, 0, 0, 0, 0, 16'h0012, 2, 0, 2'b00, 0);
    // player 1 independent
    add(1, 2'b10, 7, 1, 0, 0, 16'h0007, 1, 0, 2'b00, 0);
    add(1, 2'b10, 7, 0, 0, 0, 16'h0007, 1, 0, 2'b00, 0);
    add(1, 2'b10, 7, 1, 0, 0, 16'h0077, 2, 0, 2'b00, 0);
    add(1, 2'b10, 7, 0, 0, 0, 16'h0077, 2, 0, 2'b00, 0);
    add(1, 2'b01, 7, 0, 0, 0, 16'h0012, 2, 0, 2'b00, 0);
    // invalid selections
    add(1, 2'b11, 6, 1, 0, 0, 16'h0000, 0, 0, 2'b00, 1);
    add(1, 2'b11, 6, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b00, 6, 1, 0, 0, 16'h0000, 0, 0, 2'b00, 1);
    add(1, 2'b00, 6, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b01, 6, 0, 0, 0, 16'h0012, 2, 0, 2'b00, 0);
    // auth and del together
    add(1, 2'b01, 6, 1, 1, 0, 16'h0012, 2, 0, 2'b00, 1);
    add(1, 2'b01, 6, 0, 0, 0, 16'h0012, 2, 0, 2'b00, 0);
    // empty player 1, then del on empty
    add(1, 2'b10, 0, 0, 1, 0, 16'h0007, 1, 0, 2'b00, 0);
    add(1, 2'b10, 0, 0, 0, 0, 16'h0007, 1, 0, 2'b00, 0);
    add(1, 2'b10, 0, 0, 1, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b10, 0, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b10, 0, 0, 1, 0, 16'h0000, 0, 0, 2'b00, 1);
    add(1, 2'b10, 0, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    // log_out beats a simultaneous edge; log_out on empty is no error
    add(1, 2'b01, 8, 1, 0, 1, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b01, 8, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b01, 8, 0, 0, 1, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b01, 8, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    run_tbl("row");

    // held auth: exactly one shift
    for (int i = 0; i < 10; i++)
      add(1, 2'b01, 3, 1, 0, 0, 16'h0003, 1, 0, 2'b00, 0);
    add(1, 2'b01, 3, 0, 0, 0, 16'h0003, 1, 0, 2'b00, 0);
    run_tbl("hold");

    // fill p0, give p1 a digit, log out p0
    add(1, 2'b01, 4, 1, 0, 0, 16'h0034, 2, 0, 2'b00, 0);
    add(1, 2'b01, 4, 0, 0, 0, 16'h0034, 2, 0, 2'b00, 0);
    add(1, 2'b01, 5, 1, 0, 0, 16'h0345, 3, 0, 2'b00, 0);
    add(1, 2'b01, 5, 0, 0, 0, 16'h0345, 3, 0, 2'b00, 0);
    add(1, 2'b01, 6, 1, 0, 0, 16'h3456, 4, 1, 2'b01, 0);
    add(1, 2'b01, 6, 0, 0, 0, 16'h3456, 4, 1, 2'b01, 0);
    add(1, 2'b10, 8, 1, 0, 0, 16'h0008, 1, 0, 2'b01, 0);
    add(1, 2'b10, 8, 0, 0, 0, 16'h0008, 1, 0, 2'b01, 0);
    add(1, 2'b01, 0, 0, 0, 1, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b10, 0, 0, 0, 0, 16'h0008, 1, 0, 2'b00, 0);
    run_tbl("logout");

    // reset mid-entry with auth held through release
    add(1, 2'b10, 2, 1, 0, 0, 16'h0082, 2, 0, 2'b00, 0);
    add(0, 2'b10, 1, 1, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b10, 1, 1, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b10, 1, 1, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b10, 1, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    add(1, 2'b10, 1, 1, 0, 0, 16'h0001, 1, 0, 2'b00, 0);
    add(1, 2'b01, 1, 0, 0, 0, 16'h0000, 0, 0, 2'b00, 0);
    run_tbl("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
